// File: rtl/sdma_section_packer_pkg.sv
// Shared widths and FSM encoding for the SDMA section packer.
// Widths follow the cache data width define when one is provided.
`ifndef SDMA_CACHE_DATA_W
`define SDMA_CACHE_DATA_W 256
`endif

package sdma_section_packer_pkg;

  localparam int SSP_DATA_W = `SDMA_CACHE_DATA_W;
  localparam int SSP_BYTES  = SSP_DATA_W / 8;
  localparam int SSP_CNT_W  = $clog2(SSP_BYTES) + 1;
  // Byte-lane mask width spanning the whole accumulator.
  localparam int SSP_MASK_W = 2 * SSP_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5
  } ssp_state_e;

endpackage

// File: rtl/sdma_section_packer_byte_accum.sv
// Two-word byte accumulator: appends a section at wptr, shifts down one word, clears.
// SDMA_SSP_ZEROPAD_EN forces unstrobed output lanes to zero.
module sdma_byte_accum
  import sdma_section_packer_pkg::*;
#(
  parameter int DATA_W = SSP_DATA_W,
  parameter int CNT_W  = SSP_CNT_W,
  localparam int BYTES = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_append,
  input  logic              i_shift,
  input  logic              i_clear,
  input  logic [CNT_W-1:0]  i_wptr,
  input  logic [CNT_W-1:0]  i_num,
  input  logic [DATA_W-1:0] i_data,
  input  logic [BYTES-1:0]  i_strb,
  output logic [DATA_W-1:0] o_word
);

  localparam int ACC_W = 2 * DATA_W;
  localparam int ACC_B = 2 * BYTES;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] ins_data, ins_mask;
  logic [ACC_B-1:0] num_mask, lane_mask;

  always_comb begin
    num_mask  = (ACC_B'(1) << i_num) - ACC_B'(1);
    lane_mask = num_mask << i_wptr;
    ins_data  = ACC_W'(i_data) << {i_wptr, 3'b000};
    ins_mask  = '0;
    for (int b = 0; b < ACC_B; b++) begin
      ins_mask[b*8 +: 8] = {8{lane_mask[b]}};
    end
    acc_d = acc_q;
    if (i_clear) begin
      acc_d = '0;
    end else if (i_shift) begin
      acc_d = acc_q >> DATA_W;
    end else if (i_append) begin
      acc_d = (acc_q & ~ins_mask) | (ins_data & ins_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

`ifdef SDMA_SSP_ZEROPAD_EN
  always_comb begin
    o_word = '0;
    for (int b = 0; b < BYTES; b++) begin
      o_word[b*8 +: 8] = i_strb[b] ? acc_q[b*8 +: 8] : 8'h00;
    end
  end
`else
  logic unused_strb;
  assign unused_strb = ^i_strb;
  assign o_word      = acc_q[DATA_W-1:0];
`endif

endmodule

// File: rtl/sdma_section_packer.sv
// Packs per-section cache words into full output words; flushes on the last section.
// Optional SDMA_SSP_ZEROPAD_EN zeroes unstrobed output byte lanes.
module sdma_section_packer
  import sdma_section_packer_pkg::*;
#(
  parameter int DATA_W = SSP_DATA_W,
  parameter int CNT_W  = SSP_CNT_W,
  localparam int BYTES = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ssp_en,
  input  logic [CNT_W-1:0]  i_ssp_num_of_bytes,
  input  logic              i_ssp_fms_sel,
  input  logic              i_ssp_last,
  output logic              o_ssp_rd_req,
  output logic              o_ssp_rd_fms,
  input  logic              i_ssp_rd_gnt,
  input  logic              i_ssp_rd_vld,
  input  logic [DATA_W-1:0] i_ssp_rd_data,
  output logic              o_ssp_wr_vld,
  input  logic              i_ssp_wr_rdy,
  output logic [DATA_W-1:0] o_ssp_wr_data,
  output logic [BYTES-1:0]  o_ssp_wr_strb,
  output logic              o_ssp_outputsectiondone,
  output logic              o_ssp_busy
);

  // Output words follow valid/ready: a word transfers on a cycle with wr_vld && wr_rdy,
  // and wr_data/wr_strb stay stable while wr_vld is high and wr_rdy is low.

  ssp_state_e       state_q, state_d;
  logic [CNT_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;

  logic [CNT_W-1:0] num_clamped;
  logic [CNT_W-1:0] wptr_sum, wptr_sub;
  logic [BYTES-1:0] strb_flush;
  logic [BYTES-1:0] one_b;
  logic             acc_append, acc_shift, acc_clear;
  logic             rd_req, wr_vld, sec_done;
  logic [BYTES-1:0] wr_strb;

  assign num_clamped = (i_ssp_num_of_bytes > CNT_W'(BYTES)) ? CNT_W'(BYTES) : i_ssp_num_of_bytes;
  assign wptr_sum    = wptr_q + num_q;
  assign wptr_sub    = wptr_q - CNT_W'(BYTES);
  assign one_b       = BYTES'(1);
  assign strb_flush  = (one_b << wptr_q) - one_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      num_q   <= '0;
      sel_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      num_q   <= num_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    num_d   = num_q;
    sel_d   = sel_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (i_ssp_en) begin
          num_d  = num_clamped;
          sel_d  = i_ssp_fms_sel;
          last_d = i_ssp_last;
          if (num_clamped != '0)               state_d = ST_REQ;
          else if (i_ssp_last && wptr_q != '0) state_d = ST_FLUSH;
          else                                 state_d = ST_DONE;
        end
      end
      ST_REQ: begin
        if (i_ssp_rd_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_ssp_rd_vld) begin
          wptr_d = wptr_sum;
          if (wptr_sum >= CNT_W'(BYTES))        state_d = ST_EMIT;
          else if (last_q && wptr_sum != '0)    state_d = ST_FLUSH;
          else                                  state_d = ST_DONE;
        end
      end
      ST_EMIT: begin
        if (i_ssp_wr_rdy) begin
          wptr_d = wptr_sub;
          if (last_q && wptr_sub != '0) state_d = ST_FLUSH;
          else                          state_d = ST_DONE;
        end
      end
      ST_FLUSH: begin
        if (i_ssp_wr_rdy) begin
          wptr_d  = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_req     = 1'b0;
    wr_vld     = 1'b0;
    wr_strb    = '0;
    sec_done   = 1'b0;
    acc_append = 1'b0;
    acc_shift  = 1'b0;
    acc_clear  = 1'b0;
    case (state_q)
      ST_REQ:  rd_req = 1'b1;
      ST_WAIT: acc_append = i_ssp_rd_vld;
      ST_EMIT: begin
        wr_vld    = 1'b1;
        wr_strb   = '1;
        acc_shift = i_ssp_wr_rdy;
      end
      ST_FLUSH: begin
        wr_vld    = 1'b1;
        wr_strb   = strb_flush;
        acc_clear = i_ssp_wr_rdy;
      end
      ST_DONE: sec_done = 1'b1;
      default: ;
    endcase
  end

  assign o_ssp_rd_req            = rd_req;
  assign o_ssp_rd_fms            = rd_req & sel_q;
  assign o_ssp_wr_vld            = wr_vld;
  assign o_ssp_wr_strb           = wr_strb;
  assign o_ssp_outputsectiondone = sec_done;
  assign o_ssp_busy              = (state_q != ST_IDLE);

  sdma_byte_accum #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_append (acc_append),
    .i_shift  (acc_shift),
    .i_clear  (acc_clear),
    .i_wptr   (wptr_q),
    .i_num    (num_q),
    .i_data   (i_ssp_rd_data),
    .i_strb   (wr_strb),
    .o_word   (o_ssp_wr_data)
  );

endmodule

// File: tb/tb_sdma_section_packer.sv
// Directed bench for sdma_section_packer: section sequences, flush, backpressure, reset.
`timescale 1ns/1ps
module tb_sdma_section_packer;

  localparam int DATA_W = 256;
  localparam int BYTES  = 32;
  localparam int CNT_W  = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [CNT_W-1:0]  num = '0;
  logic              sel = 1'b0;
  logic              last = 1'b0;
  logic              rd_req, rd_fms;
  logic              gnt = 1'b0;
  logic              vld = 1'b0;
  logic [DATA_W-1:0] rd_data = '0;
  logic              wr_vld;
  logic              rdy = 1'b1;
  logic [DATA_W-1:0] wr_data;
  logic [BYTES-1:0]  wr_strb;
  logic              done, busy;

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [BYTES-1:0]  exp_strb_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sdma_section_packer dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .i_ssp_en                (en),
    .i_ssp_num_of_bytes      (num),
    .i_ssp_fms_sel           (sel),
    .i_ssp_last              (last),
    .o_ssp_rd_req            (rd_req),
    .o_ssp_rd_fms            (rd_fms),
    .i_ssp_rd_gnt            (gnt),
    .i_ssp_rd_vld            (vld),
    .i_ssp_rd_data           (rd_data),
    .o_ssp_wr_vld            (wr_vld),
    .i_ssp_wr_rdy            (rdy),
    .o_ssp_wr_data           (wr_data),
    .o_ssp_wr_strb           (wr_strb),
    .o_ssp_outputsectiondone (done),
    .o_ssp_busy              (busy)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input logic [7:0] base);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < BYTES; i++) w[i*8 +: 8] = 8'(base + i);
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] fill(input logic [DATA_W-1:0] w_in, input int dst,
                                             input logic [7:0] start, input int cnt);
    logic [DATA_W-1:0] w;
    w = w_in;
    for (int k = 0; k < cnt; k++) w[(dst+k)*8 +: 8] = 8'(start + k);
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] lane_mask(input logic [BYTES-1:0] s);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < BYTES; b++) m[b*8 +: 8] = {8{s[b]}};
    return m;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic score_word();
    logic [DATA_W-1:0] ed;
    logic [BYTES-1:0]  es;
    if (exp_q.size() == 0) begin
      chk("unexpected_word", DATA_W'(wr_strb), '0);
    end else begin
      ed = exp_q.pop_front();
      es = exp_strb_q.pop_front();
      chk("wr_strb", DATA_W'(wr_strb), DATA_W'(es));
`ifdef SDMA_SSP_ZEROPAD_EN
      chk("wr_data", wr_data, ed);
`else
      chk("wr_data", wr_data & lane_mask(es), ed & lane_mask(es));
`endif
    end
  endtask

  task automatic expect_word(input logic [DATA_W-1:0] d, input logic [BYTES-1:0] s);
    exp_q.push_back(d);
    exp_strb_q.push_back(s);
  endtask

  // ---------------- driver ----------------
  // Drives one section as controller plus cache plus sink; lat counts cycles from the
  // cycle en is presented to the done cycle.
  task automatic run_section(input int n, input bit s, input bit l, input logic [DATA_W-1:0] d,
                             input int stall, output int lat, output int reqs);
    int                stalls;
    bit                granted, seen_done;
    logic [DATA_W-1:0] held_d;
    logic [BYTES-1:0]  held_s;
    @(negedge clk);
    en = 1'b1; num = n[CNT_W-1:0]; sel = s; last = l;
    gnt = 1'b0; vld = 1'b0; rdy = 1'b1;
    lat = 0; reqs = 0; stalls = 0; granted = 1'b0; seen_done = 1'b0;
    held_d = '0; held_s = '0;
    while (!seen_done && lat < 60) begin
      @(negedge clk);
      lat++;
      en = 1'b0;
      vld = granted;
      rd_data = granted ? d : '0;
      granted = 1'b0;
      gnt = 1'b0;
      if (rd_req) begin
        reqs++;
        chk("rd_fms", DATA_W'(rd_fms), DATA_W'(s));
        gnt = 1'b1;
        granted = 1'b1;
      end
      rdy = 1'b1;
      if (wr_vld) begin
        if (stalls > 0) begin
          chk("hold_data", wr_data, held_d);
          chk("hold_strb", DATA_W'(wr_strb), DATA_W'(held_s));
        end
        if (stalls < stall) begin
          if (stalls == 0) begin
            held_d = wr_data;
            held_s = wr_strb;
          end
          stalls++;
          rdy = 1'b0;
        end else begin
          score_word();
        end
      end
      if (done) seen_done = 1'b1;
    end
    gnt = 1'b0; vld = 1'b0; rdy = 1'b1;
    if (!seen_done) begin
      chk("done_timeout", '0, DATA_W'(1));
    end else begin
      @(negedge clk);
      chk("done_pulse_width", DATA_W'(done), '0);
      chk("idle_after_done", DATA_W'(busy), '0);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rd_req"}, DATA_W'(rd_req), '0);
    chk({tag, "_rd_fms"}, DATA_W'(rd_fms), '0);
    chk({tag, "_wr_vld"}, DATA_W'(wr_vld), '0);
    chk({tag, "_wr_data"}, wr_data, '0);
    chk({tag, "_wr_strb"}, DATA_W'(wr_strb), '0);
    chk({tag, "_done"}, DATA_W'(done), '0);
    chk({tag, "_busy"}, DATA_W'(busy), '0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat, reqs;
    logic [DATA_W-1:0] w;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Single full section, fms2
    expect_word(pat(8'h00), 32'hFFFF_FFFF);
    run_section(32, 1'b1, 1'b1, pat(8'h00), 0, lat, reqs);
    chk("t1_latency", DATA_W'(lat), DATA_W'(4));
    chk("t1_reqs", DATA_W'(reqs), DATA_W'(1));

    // 20 + 20 + 8: one full word after section 2, 16-byte flush after section 3
    run_section(20, 1'b0, 1'b0, pat(8'h10), 0, lat, reqs);
    chk("t2a_latency", DATA_W'(lat), DATA_W'(3));
    w = fill('0, 0, 8'h10, 20);
    w = fill(w, 20, 8'h40, 12);
    expect_word(w, 32'hFFFF_FFFF);
    run_section(20, 1'b0, 1'b0, pat(8'h40), 0, lat, reqs);
    chk("t2b_latency", DATA_W'(lat), DATA_W'(4));
    w = fill('0, 0, 8'h4C, 8);
    w = fill(w, 8, 8'h70, 8);
    expect_word(w, 32'h0000_FFFF);
    run_section(8, 1'b0, 1'b1, pat(8'h70), 0, lat, reqs);
    chk("t2c_latency", DATA_W'(lat), DATA_W'(4));
    chk("t2_words_left", DATA_W'(exp_q.size()), '0);

    // Empty last section with nothing pending
    run_section(0, 1'b0, 1'b1, pat(8'h55), 0, lat, reqs);
    chk("t3_latency", DATA_W'(lat), DATA_W'(1));
    chk("t3_reqs", DATA_W'(reqs), '0);

    // Empty last section with 5 bytes pending flushes them
    run_section(5, 1'b0, 1'b0, pat(8'h90), 0, lat, reqs);
    expect_word(fill('0, 0, 8'h90, 5), 32'h0000_001F);
    run_section(0, 1'b0, 1'b1, pat(8'h33), 0, lat, reqs);
    chk("t3b_latency", DATA_W'(lat), DATA_W'(2));
    chk("t3b_reqs", DATA_W'(reqs), '0);

    // Backpressure: 5 stalled cycles in EMIT
    expect_word(pat(8'hC0), 32'hFFFF_FFFF);
    run_section(32, 1'b1, 1'b1, pat(8'hC0), 5, lat, reqs);
    chk("t4_latency", DATA_W'(lat), DATA_W'(9));

    // Oversized count clamps to one full word
    expect_word(pat(8'h20), 32'hFFFF_FFFF);
    run_section(40, 1'b0, 1'b1, pat(8'h20), 0, lat, reqs);
    chk("t5_latency", DATA_W'(lat), DATA_W'(4));

    // Partial flush of 3 bytes
    expect_word(fill('0, 0, 8'hE0, 3), 32'h0000_0007);
    run_section(3, 1'b1, 1'b1, pat(8'hE0), 0, lat, reqs);
    chk("t6_latency", DATA_W'(lat), DATA_W'(4));

    // Leave 10 bytes pending, then reset while waiting for read data
    run_section(10, 1'b0, 1'b0, pat(8'h80), 0, lat, reqs);
    @(negedge clk);
    en = 1'b1; num = 6'd7; sel = 1'b0; last = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("t7_rd_req", DATA_W'(rd_req), DATA_W'(1));
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    chk("t7_busy_wait", DATA_W'(busy), DATA_W'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("t7_reset");
    rst_n = 1'b1;
    expect_word(fill('0, 0, 8'hA0, 4), 32'h0000_000F);
    run_section(4, 1'b0, 1'b1, pat(8'hA0), 0, lat, reqs);
    chk("t7_latency", DATA_W'(lat), DATA_W'(4));

    chk("words_left", DATA_W'(exp_q.size()), '0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
